// File: rtl/calc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_sequencer_if                                         |
// | Brief    : Board-input / ALU / display bundle for calc_sequencer.     |
// |            master = sequencer view, slave = board + ALU view.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface calc_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter int RES_W  = 8
);
  logic [DATA_W-1:0] in_number;
  logic [OP_W-1:0]   arif;
  logic [1:0]        key;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic              alu_start;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              err;
  logic [2:0]        led;
  logic [2:0]        stage;

  modport master (
    input  in_number, arif, key, alu_done, alu_result,
    output op_a, op_b, op_code, alu_start, result, result_valid, err, led, stage
  );

  modport slave (
    output in_number, arif, key, alu_done, alu_result,
    input  op_a, op_b, op_code, alu_start, result, result_valid, err, led, stage
  );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_sequencer                                            |
// | Brief    : Debounces ENTER/CLEAR, collects operand A, operator and   |
// |            operand B, pulses alu_start, waits for alu_done with a    |
// |            timeout and holds the result for display.                 |
// | Options  : CALC_SEQ_CHAIN_EN - ENTER in S_SHOW (no error) reuses the |
// |            result as operand A and jumps straight to operator entry. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module calc_sequencer #(
  parameter int DATA_W      = 4,
  parameter int OP_W        = 4,
  parameter int RES_W       = 8,
  parameter int DB_CYCLES   = 500000,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  calc_sequencer_if.master bus
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic [1:0] press;

  // One debouncer per button: index 0 is ENTER, index 1 is CLEAR.
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    // Count consecutive low samples; fire once, then wait for release to rearm.
    always_comb begin
      sync_d  = {sync_q[0], bus.key[i]};
      cnt_d   = cnt_q;
      armed_d = armed_q;
      press_d = 1'b0;
      if (sync_q[1]) begin
        cnt_d   = '0;
        armed_d = 1'b1;
      end else if (armed_q) begin
        if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
          press_d = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Synchronizer and debounce state registers (buttons idle high).
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= 2'b11;
        cnt_q   <= '0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        press_q <= press_d;
      end
    end

    assign press[i] = press_q;
  end

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]     op_code_q, op_code_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                enter, clear;

  assign enter = press[0];
  assign clear = press[1];

  // Next-state and datapath updates; CLEAR overrides everything, ENTER steps the flow.
  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_code_d      = op_code_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    tmo_d          = '0;
    if (clear) begin
      state_d        = S_A;
      op_a_d         = '0;
      op_b_d         = '0;
      op_code_d      = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
      err_d          = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter) begin
            op_a_d  = ~bus.in_number;
            err_d   = 1'b0;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (enter) begin
            if (&bus.arif) begin
              err_d = 1'b1;
            end else begin
              op_code_d = bus.arif;
              err_d     = 1'b0;
              state_d   = S_B;
            end
          end
        end
        S_B: begin
          if (enter) begin
            op_b_d  = ~bus.in_number;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          // tmo_q counts cycles spent here; zero is the alu_start cycle.
          tmo_d = tmo_q + TMO_W'(1);
          if ((tmo_q != '0) && bus.alu_done) begin
            result_d       = bus.alu_result;
            result_valid_d = 1'b1;
            state_d        = S_SHOW;
            tmo_d          = '0;
          end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
            result_d       = '0;
            result_valid_d = 1'b1;
            err_d          = 1'b1;
            state_d        = S_SHOW;
            tmo_d          = '0;
          end
        end
        S_SHOW: begin
          if (enter) begin
            result_valid_d = 1'b0;
`ifdef CALC_SEQ_CHAIN_EN
            if (err_q) begin
              state_d = S_A;
            end else begin
              op_a_d  = result_q[DATA_W-1:0];
              state_d = S_OP;
            end
`else
            state_d = S_A;
`endif
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // Sequencer state and latched operands/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_code_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_code_q      <= op_code_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      tmo_q          <= tmo_d;
    end
  end

  // Stage LEDs, active-low one-cold; all off while executing, all on when showing.
  always_comb begin
    bus.led = 3'b110;
    case (state_q)
      S_A:     bus.led = 3'b110;
      S_OP:    bus.led = 3'b101;
      S_B:     bus.led = 3'b011;
      S_EXEC:  bus.led = 3'b111;
      S_SHOW:  bus.led = 3'b000;
      default: bus.led = 3'b110;
    endcase
  end

  assign bus.alu_start    = (state_q == S_EXEC) && (tmo_q == '0);
  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.op_code      = op_code_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err          = err_q;
  assign bus.stage        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_calc_sequencer                                         |
// | Brief    : Scoreboard bench for calc_sequencer with a reactive ALU   |
// |            responder and randomized operand/operator/outcome mix.    |
// |            Honours CALC_SEQ_CHAIN_EN when defined.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_calc_sequencer;
  localparam int DATA_W      = 4;
  localparam int OP_W        = 4;
  localparam int RES_W       = 8;
  localparam int DB_CYCLES   = 4;
  localparam int ALU_TIMEOUT = 16;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } start_t;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
    logic [7:0] lat;
  } show_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W)) bus ();

  calc_sequencer #(
    .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W),
    .DB_CYCLES(DB_CYCLES), .ALU_TIMEOUT(ALU_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  start_t exp_start_q[$];
  show_t  exp_show_q[$];

  int         resp_mode  = 0;
  int         resp_delay = 1;
  logic [7:0] resp_val   = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_op_a"}, int'(bus.op_a), 0);
    chk({tag, "_op_b"}, int'(bus.op_b), 0);
    chk({tag, "_op_code"}, int'(bus.op_code), 0);
    chk({tag, "_alu_start"}, int'(bus.alu_start), 0);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_led"}, int'(bus.led), 6);
    chk({tag, "_stage"}, int'(bus.stage), 0);
  endtask

  // Hold the selected keys low for n_low cycles, then release and let it settle.
  task automatic press(input logic [1:0] keys_low, input int n_low);
    @(posedge clk); #1;
    bus.key = ~keys_low;
    repeat (n_low) @(posedge clk);
    #1;
    bus.key = 2'b11;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ALU model: answers an alu_start after resp_delay cycles when enabled.
  initial begin
    int         d;
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (!rst && bus.alu_start && resp_mode != 0) begin
        d = resp_delay;
        v = resp_val;
        repeat (d) @(posedge clk);
        #1;
        bus.alu_done   = 1'b1;
        bus.alu_result = v;
        @(posedge clk); #1;
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'h00;
      end
    end
  end

  // Monitor: pops the scoreboard on every alu_start and every entry into S_SHOW.
  initial begin
    logic       prev_start;
    logic [2:0] prev_stage;
    int         start_cyc;
    start_t     s;
    show_t      sh;
    prev_start = 1'b0;
    prev_stage = 3'd0;
    start_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0;
        prev_stage = 3'd0;
      end else begin
        if (bus.alu_start) begin
          chk("start_single_cycle", int'(prev_start), 0);
          chk("start_expected", int'(exp_start_q.size() != 0), 1);
          if (exp_start_q.size() != 0) begin
            s = exp_start_q.pop_front();
            chk("start_op_a", int'(bus.op_a), int'(s.a));
            chk("start_op_b", int'(bus.op_b), int'(s.b));
            chk("start_op_code", int'(bus.op_code), int'(s.op));
          end
          start_cyc = cyc;
        end
        if (bus.stage == 3'd4 && prev_stage != 3'd4) begin
          chk("show_expected", int'(exp_show_q.size() != 0), 1);
          if (exp_show_q.size() != 0) begin
            sh = exp_show_q.pop_front();
            chk("show_result", int'(bus.result), int'(sh.res));
            chk("show_err", int'(bus.err), int'(sh.err));
            chk("show_latency", cyc - start_cyc, int'(sh.lat));
            chk("show_led", int'(bus.led), 0);
            chk("show_result_valid", int'(bus.result_valid), 1);
          end
        end
        prev_start = bus.alu_start;
        prev_stage = bus.stage;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus and reference model.
  initial begin
    logic [3:0] a_raw, b_raw, op, exp_a, exp_b, res_lo;
    logic [7:0] val;
    logic       exp_err;
    int         st_model, scen, d;
    show_t      sh;
    start_t     st;

    bus.key        = 2'b11;
    bus.in_number  = 4'h0;
    bus.arif       = 4'h0;
    bus.alu_done   = 1'b0;
    bus.alu_result = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Short glitch: three low cycles never reach the debounce count.
    #1; bus.key = 2'b10;
    repeat (3) @(posedge clk);
    #1; bus.key = 2'b11;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("db_short_stage", int'(bus.stage), 0);
    chk("db_short_led", int'(bus.led), 6);

    bus.in_number = 4'b0110;
    press(2'b01, 6);
    @(negedge clk);
    chk("db_press_stage", int'(bus.stage), 1);
    chk("db_press_led", int'(bus.led), 5);
    chk("db_press_op_a", int'(bus.op_a), 9);

    press(2'b10, 6);
    @(negedge clk);
    chk("clear_stage", int'(bus.stage), 0);
    chk("clear_op_a", int'(bus.op_a), 0);

    // Long hold must count as a single press.
    bus.arif = 4'h0;
    press(2'b01, 20);
    @(negedge clk);
    chk("no_repeat_stage", int'(bus.stage), 1);

    // Reset in the middle of an entry.
    bus.arif = 4'h3;
    press(2'b01, 6);
    @(negedge clk);
    chk("pre_rst_stage", int'(bus.stage), 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    st_model = 0;
    exp_a    = 4'h0;
    for (int it = 0; it < 10; it++) begin
      scen = (it < 3) ? it : int'($urandom_range(0, 2));
      if (st_model == 0) begin
        a_raw = (it == 0) ? 4'b1100 : 4'($urandom_range(0, 15));
        exp_a = ~a_raw;
        bus.in_number = a_raw;
        press(2'b01, 6);
        @(negedge clk);
        chk("a_stage", int'(bus.stage), 1);
        chk("a_op_a", int'(bus.op_a), int'(exp_a));
        chk("a_err", int'(bus.err), 0);
        chk("a_led", int'(bus.led), 5);
      end else begin
        chk("chain_op_a", int'(bus.op_a), int'(exp_a));
      end

      if (it == 0 || $urandom_range(0, 2) == 0) begin
        bus.arif = 4'hF;
        press(2'b01, 6);
        @(negedge clk);
        chk("bad_op_err", int'(bus.err), 1);
        chk("bad_op_stage", int'(bus.stage), 1);
      end

      op = (it == 0) ? 4'h2 : 4'($urandom_range(0, 14));
      bus.arif = op;
      press(2'b01, 6);
      @(negedge clk);
      chk("op_stage", int'(bus.stage), 2);
      chk("op_err", int'(bus.err), 0);
      chk("op_code", int'(bus.op_code), int'(op));
      chk("op_led", int'(bus.led), 3);

      b_raw = (it == 0) ? 4'b1010 : 4'($urandom_range(0, 15));
      exp_b = ~b_raw;
      bus.in_number = b_raw;
      st.a  = exp_a;
      st.b  = exp_b;
      st.op = op;
      exp_start_q.push_back(st);

      d   = 13;
      val = 8'($urandom_range(0, 255));
      exp_err = 1'b0;
      if (scen == 0) begin
        d = (it == 0) ? 3 : int'($urandom_range(1, ALU_TIMEOUT - 1));
        if (it == 0) val = 8'h08;
        resp_mode = 1;
        sh.res = val;
        sh.err = 1'b0;
        sh.lat = 8'(d + 1);
        exp_show_q.push_back(sh);
      end else if (scen == 1) begin
        resp_mode = 0;
        exp_err   = 1'b1;
        val       = 8'h00;
        sh.res = 8'h00;
        sh.err = 1'b1;
        sh.lat = 8'(ALU_TIMEOUT);
        exp_show_q.push_back(sh);
      end else begin
        resp_mode = 1;
      end
      resp_delay = d;
      resp_val   = val;
      press(2'b01, 6);

      if (scen == 2) begin
        // Both keys during execution: CLEAR wins, late alu_done is ignored.
        press(2'b11, 6);
        repeat (20) @(negedge clk);
        chk("abort_stage", int'(bus.stage), 0);
        chk("abort_op_a", int'(bus.op_a), 0);
        chk("abort_op_b", int'(bus.op_b), 0);
        chk("abort_op_code", int'(bus.op_code), 0);
        chk("abort_result_valid", int'(bus.result_valid), 0);
        chk("abort_result", int'(bus.result), 0);
        st_model = 0;
      end else begin
        for (int w = 0; w < 40 && bus.stage != 3'd4; w++) @(negedge clk);
        chk("show_reached", int'(bus.stage), 4);
        press(2'b01, 6);
        @(negedge clk);
        chk("leave_result_valid", int'(bus.result_valid), 0);
`ifdef CALC_SEQ_CHAIN_EN
        if (!exp_err) begin
          res_lo = val[3:0];
          exp_a  = res_lo;
          chk("leave_stage", int'(bus.stage), 1);
          st_model = 1;
        end else begin
          chk("leave_stage", int'(bus.stage), 0);
          st_model = 0;
        end
`else
        chk("leave_stage", int'(bus.stage), 0);
        st_model = 0;
`endif
      end
    end

    repeat (5) @(negedge clk);
    chk("start_q_drained", exp_start_q.size(), 0);
    chk("show_q_drained", exp_show_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
